// File: rtl/ov7670_frame_ctrl.sv
// Frame sequencer for the OV7670 capture path: arms on start, aligns to a frame boundary,
// gates capture vsync, checks frame geometry and flips the double-buffer select on good frames.
module ov7670_frame_ctrl #(
    parameter int unsigned X_MAX       = 640,
    parameter int unsigned Y_MAX       = 480,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    input  logic        vsync,
    input  logic        href,
    input  logic        pix_we,
    output logic        cap_vsync,
    output logic        buf_sel,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count,
    output logic [8:0]  last_lines,
    output logic [18:0] last_pixels
);

    typedef enum logic [1:0] {StIdle, StWaitFall, StActive} state_e;

    localparam logic [8:0]  LinesExp  = 9'(Y_MAX);
    localparam logic [18:0] PixelsExp = 19'(X_MAX * Y_MAX);
    // The counter holds cycles already spent, so the TIMEOUT_CYC-th cycle fires the timeout.
    localparam logic [23:0] TmoLast   = 24'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ErrNone  = 2'd0;
    localparam logic [1:0] ErrTmo   = 2'd1;
    localparam logic [1:0] ErrLines = 2'd2;
    localparam logic [1:0] ErrPix   = 2'd3;

    state_e      state_q, state_d;
    logic        vs_q, href_q;
    logic        cont_q, cont_d;
    logic [8:0]  lines_q, lines_d;
    logic [18:0] pixels_q, pixels_d;
    logic [23:0] tmo_q, tmo_d;
    logic        buf_sel_q, buf_sel_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [8:0]  last_lines_q, last_lines_d;
    logic [18:0] last_pixels_q, last_pixels_d;

    logic        vs_fall, vs_rise, line_start, tmo_hit;
    logic [8:0]  lines_inc;
    logic [18:0] pixels_inc;

    assign vs_fall    = vs_q & ~vsync;
    assign vs_rise    = ~vs_q & vsync;
    assign line_start = ~href_q & href;
    assign tmo_hit    = (tmo_q == TmoLast);

    // Counts include the current cycle so a strobe in the end-of-frame cycle is evaluated.
    assign lines_inc  = (line_start && lines_q != 9'h1FF) ? lines_q + 9'd1 : lines_q;
    assign pixels_inc = (pix_we && pixels_q != 19'h7FFFF) ? pixels_q + 19'd1 : pixels_q;

    always_comb begin
        state_d       = state_q;
        cont_d        = cont_q;
        lines_d       = lines_q;
        pixels_d      = pixels_q;
        tmo_d         = tmo_q;
        buf_sel_d     = buf_sel_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_count_d = frame_count_q;
        last_lines_d  = last_lines_q;
        last_pixels_d = last_pixels_q;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d    = StWaitFall;
                        cont_d     = continuous;
                        err_code_d = ErrNone;
                        tmo_d      = '0;
                    end
                end
                StWaitFall: begin
                    if (vs_fall) begin
                        state_d  = StActive;
                        lines_d  = '0;
                        pixels_d = '0;
                        tmo_d    = '0;
                    end else if (tmo_hit) begin
                        state_d     = StIdle;
                        err_code_d  = ErrTmo;
                        frame_err_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 24'd1;
                    end
                end
                StActive: begin
                    lines_d  = lines_inc;
                    pixels_d = pixels_inc;
                    tmo_d    = tmo_q + 24'd1;
                    if (vs_rise) begin
                        last_lines_d  = lines_inc;
                        last_pixels_d = pixels_inc;
                        state_d       = cont_q ? StWaitFall : StIdle;
                        if (lines_inc != LinesExp) begin
                            err_code_d  = ErrLines;
                            frame_err_d = 1'b1;
                        end else if (pixels_inc != PixelsExp) begin
                            err_code_d  = ErrPix;
                            frame_err_d = 1'b1;
                        end else begin
                            frame_done_d  = 1'b1;
                            buf_sel_d     = ~buf_sel_q;
                            frame_count_d = frame_count_q + 16'd1;
                        end
                    end else if (tmo_hit) begin
                        state_d     = StIdle;
                        err_code_d  = ErrTmo;
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= StIdle;
            vs_q          <= 1'b1;
            href_q        <= 1'b0;
            cont_q        <= 1'b0;
            lines_q       <= '0;
            pixels_q      <= '0;
            tmo_q         <= '0;
            buf_sel_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ErrNone;
            frame_count_q <= '0;
            last_lines_q  <= '0;
            last_pixels_q <= '0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vsync;
            href_q        <= href;
            cont_q        <= cont_d;
            lines_q       <= lines_d;
            pixels_q      <= pixels_d;
            tmo_q         <= tmo_d;
            buf_sel_q     <= buf_sel_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_count_q <= frame_count_d;
            last_lines_q  <= last_lines_d;
            last_pixels_q <= last_pixels_d;
        end
    end

    // Outside ACTIVE the capture block is held in its vsync (reset) state.
    assign cap_vsync   = vsync | (state_q != StActive);
    assign busy        = (state_q != StIdle);
    assign buf_sel     = buf_sel_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign frame_count = frame_count_q;
    assign last_lines  = last_lines_q;
    assign last_pixels = last_pixels_q;

endmodule
